// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer: state encoding and
// the shared-timer width calculation.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_PULSE     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } pll_state_e;

  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_seq_sync2.sv
// Generic two-flop synchronizer with asynchronous active-low clear.
module pll_seq_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, filters lock, releases the
// core reset, retries on timeout and latches a fault after MAX_RETRY failures.
// Optional lock-loss/timeout statistics under PLL_RESET_SEQUENCER_STATS_EN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_FILTER_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 500000,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic                           refclk,
  input  logic                           rst_n,
  input  logic                           pll_locked,
  input  logic                           req_reset,
  output logic                           pll_rst,
  output logic                           sys_reset,
  output logic                           ready,
  output logic                           fault,
  output logic [2:0]                     state_o,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
`ifdef PLL_RESET_SEQUENCER_STATS_EN
  ,
  output logic [7:0]                     lock_loss_cnt,
  output logic [7:0]                     timeout_cnt
`endif
);

  localparam int unsigned TW = timer_width(RST_PULSE_CYC, LOCK_FILTER_CYC, LOCK_TIMEOUT_CYC);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] PULSE_LAST   = TW'(RST_PULSE_CYC - 1);
  localparam logic [TW-1:0] FILTER_LAST  = TW'(LOCK_FILTER_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);

  pll_state_e    state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [RW-1:0] retry_nx, retry_inc;
  logic          locked_s;

  pll_seq_sync2 #(.WIDTH(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_nx  = state;
    retry_nx  = retry_cnt;
    retry_inc = retry_cnt + RW'(1);
    if (req_reset) begin
      state_nx = S_PULSE;
      retry_nx = '0;
    end else begin
      case (state)
        S_PULSE:     if (timer == PULSE_LAST) state_nx = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          // lock seen on the timeout cycle still wins
          if (locked_s) begin
            state_nx = S_FILTER;
          end else if (timer == TIMEOUT_LAST) begin
            retry_nx = retry_inc;
            state_nx = (retry_inc == RW'(MAX_RETRY)) ? S_FAULT : S_PULSE;
          end
        end
        S_FILTER: begin
          if (!locked_s) begin
            state_nx = S_WAIT_LOCK;
          end else if (timer == FILTER_LAST) begin
            state_nx = S_RUN;
            retry_nx = '0;
          end
        end
        S_RUN:       if (!locked_s) state_nx = S_PULSE;
        S_FAULT:     state_nx = S_FAULT;
        default:     state_nx = S_PULSE;
      endcase
    end

    if (req_reset || (state_nx != state)) begin
      timer_nx = '0;
    end else if (state == S_PULSE || state == S_WAIT_LOCK || state == S_FILTER) begin
      timer_nx = timer + TW'(1);
    end else begin
      timer_nx = timer;
    end
  end

  // Outputs are registered from the next-state decode so they track state exactly.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PULSE;
      timer     <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      retry_cnt <= retry_nx;
      pll_rst   <= (state_nx == S_PULSE);
      sys_reset <= (state_nx != S_RUN);
      ready     <= (state_nx == S_RUN);
      fault     <= (state_nx == S_FAULT);
    end
  end

  assign state_o = state;

`ifdef PLL_RESET_SEQUENCER_STATS_EN
  logic timeout_ev, loss_ev;

  assign timeout_ev = !req_reset && (state == S_WAIT_LOCK) && !locked_s && (timer == TIMEOUT_LAST);
  assign loss_ev    = !req_reset && (state == S_RUN) && !locked_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt <= '0;
      timeout_cnt   <= '0;
    end else begin
      if (loss_ev && (lock_loss_cnt != '1)) lock_loss_cnt <= lock_loss_cnt + 8'd1;
      if (timeout_ev && (timeout_cnt != '1)) timeout_cnt <= timeout_cnt + 8'd1;
    end
  end
`else
  // statistics counters are not built in this configuration
`endif

endmodule
